// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request side and a valid/ready
// result side. Most operations finish in a single cycle. MUL uses an
// iterative shift-add multiplier that retires one multiplier bit per cycle.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready request handshake (in_ready is combinational)
//   src1, src2          operands A and B, WIDTH bits each
//   ALU_control         4-bit opcode
//   out_valid/out_ready result handshake
//   result              registered result, WIDTH bits
//   zero, cout,
//   overflow, illegal   registered flags that travel with result
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             illegal
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd10;
    localparam logic [3:0] OP_NOR = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Control decode from the FSM output process
    logic accept;
    logic mul_step;
    logic mul_last;
    logic is_mul;

    // Multiplier state: {hi_q, lo_q} is the running product; lo_q starts
    // out holding the multiplier and is consumed from bit 0 upwards.
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] hi_nx;
    logic [WIDTH-1:0] lo_nx;

    // Single-cycle datapath
    logic             sub_sel;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH:0]   add_full;
    logic             add_ovf;
    logic             slt_bit;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_ill;

    // Output registers
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             cout_q;
    logic             overflow_q;
    logic             illegal_q;

    assign is_mul = (ALU_control == OP_MUL);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = is_mul ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (mul_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Draining the result either returns to IDLE or takes the
                // next request on the same edge.
                if (accept) begin
                    state_d = is_mul ? S_BUSY : S_DONE;
                end else if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = 1'b0;
        mul_step = 1'b0;
        mul_last = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_BUSY: begin
                mul_step = 1'b1;
                mul_last = (cnt_q == SHW'(WIDTH - 1));
            end
            S_DONE: begin
                in_ready = out_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
        accept = in_valid && in_ready;
    end

    // One shift-add step: add the multiplicand when the current multiplier
    // bit is set, then shift the whole {carry, hi, lo} right by one.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign hi_nx   = mul_sum[WIDTH:1];
    assign lo_nx   = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Multiplier registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else if (accept && is_mul) begin
            mcand_q <= src1;
            hi_q    <= '0;
            lo_q    <= src2;
            cnt_q   <= '0;
        end else if (mul_step) begin
            hi_q    <= hi_nx;
            lo_q    <= lo_nx;
            cnt_q   <= cnt_q + SHW'(1);
        end
    end

    // Shared adder: SUB is src1 + ~src2 + 1
    assign sub_sel  = (ALU_control == OP_SUB);
    assign add_b    = sub_sel ? ~src2 : src2;
    assign add_full = {1'b0, src1} + {1'b0, add_b} + {{WIDTH{1'b0}}, sub_sel};
    assign add_ovf  = (src1[WIDTH-1] == add_b[WIDTH-1]) &&
                      (add_full[WIDTH-1] != src1[WIDTH-1]);
    // Direct signed compare stays correct when src1-src2 would overflow
    assign slt_bit  = ($signed(src1) < $signed(src2));
    assign shamt    = src2[SHW-1:0];

    // Single-cycle operation results
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (ALU_control)
            OP_AND: alu_res = src1 & src2;
            OP_OR:  alu_res = src1 | src2;
            OP_NOR: alu_res = ~(src1 | src2);
            OP_ADD, OP_SUB: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = add_ovf;
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_SLL: alu_res = src1 << shamt;
            OP_SRL: alu_res = src1 >> shamt;
            OP_SRA: alu_res = WIDTH'($unsigned($signed(src1) >>> shamt));
            OP_MUL: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // Result and flag registers; held while waiting in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= (state_d == S_DONE);
            if (accept && !is_mul) begin
                result_q   <= alu_res;
                zero_q     <= (alu_res == '0);
                cout_q     <= alu_c;
                overflow_q <= alu_v;
                illegal_q  <= alu_ill;
            end else if (mul_last) begin
                result_q   <= lo_nx;
                zero_q     <= (lo_nx == '0);
                cout_q     <= (hi_nx != '0);
                overflow_q <= 1'b0;
                illegal_q  <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic [3:0]   ALU_control;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         cout;
    logic         overflow;
    logic         illegal;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src1        (src1),
        .src2        (src2),
        .ALU_control (ALU_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .cout        (cout),
        .overflow    (overflow),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request and let it be accepted on the next edge
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        ALU_control = op;
        src1        = a;
        src2        = b;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
    endtask

    // Single-cycle op: result must be valid right after the accept edge
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_r,
                          input logic [3:0] exp_zcvi);
        issue(op, a, b);
        chk({tag, "_valid"}, W'(out_valid), W'(1));
        chk({tag, "_res"}, result, exp_r);
        chk({tag, "_zcvi"}, W'({zero, cout, overflow, illegal}), W'(exp_zcvi));
    endtask

    task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_r, input logic [3:0] exp_zcvi);
        int n;
        issue(4'd3, a, b);
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, W'(n), W'(33));
        chk({tag, "_res"}, result, exp_r);
        chk({tag, "_zcvi"}, W'({zero, cout, overflow, illegal}), W'(exp_zcvi));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a request pending: it must not be taken
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        ALU_control = 4'd2;
        src1        = 32'h0000_0001;
        src2        = 32'h0000_0001;
        tick();
        tick();
        chk("rst_outs", W'({out_valid, zero, cout, overflow, illegal}), W'(0));
        chk("rst_result", result, 32'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("post_rst_ready", W'(in_ready), W'(1));
        tick();
        chk("post_rst_no_valid", W'(out_valid), W'(0));

        // Single-cycle ops, back to back with out_ready held high
        run_op("add_ovf",  4'd2,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0010);
        run_op("sub_eq",   4'd6,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1100);
        run_op("slt_neg",  4'd7,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 4'b0000);
        run_op("slt_ovf",  4'd7,  32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 4'b1000);
        run_op("sra",      4'd10, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 4'b0000);
        run_op("illegal_f",4'd15, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 4'b1001);
        run_op("and",      4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0000);
        run_op("or",       4'd1,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 4'b0000);
        run_op("nor",      4'd12, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0000);
        run_op("sll",      4'd8,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 4'b0000);
        run_op("srl",      4'd9,  32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 4'b0000);
        run_op("sub_brw",  4'd6,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0000);
        run_op("sub_ovf",  4'd6,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0110);
        run_op("add_wrap", 4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1100);
        run_op("illegal_4",4'd4,  32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 4'b1001);

        // Drain to IDLE
        tick();
        chk("idle_valid", W'(out_valid), W'(0));
        chk("idle_ready", W'(in_ready), W'(1));

        // MUL with stalled consumer and a request waiting during BUSY
        issue(4'd3, 32'h0001_0000, 32'h0001_0000);
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        ALU_control = 4'd2;
        src1        = 32'h0000_0001;
        src2        = 32'h0000_0002;
        for (int i = 1; i <= 32; i++) begin
            chk($sformatf("mul_busy_%0d", i), W'({out_valid, in_ready}), W'(0));
            tick();
        end
        chk("mul_done_valid", W'(out_valid), W'(1));
        chk("mul_done_res", result, 32'h0);
        chk("mul_done_zcvi", W'({zero, cout, overflow, illegal}), W'(4'b1100));
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("hold_valid_%0d", i), W'(out_valid), W'(1));
            chk($sformatf("hold_res_%0d", i), result, 32'h0);
            chk($sformatf("hold_zcvi_%0d", i), W'({zero, cout, overflow, illegal}), W'(4'b1100));
        end
        out_ready = 1'b1;
        #1;
        chk("drain_ready", W'(in_ready), W'(1));
        tick();
        in_valid = 1'b0;
        chk("b2b_valid", W'(out_valid), W'(1));
        chk("b2b_res", result, 32'h0000_0003);
        chk("b2b_zcvi", W'({zero, cout, overflow, illegal}), W'(4'b0000));
        tick();
        chk("b2b_idle", W'(out_valid), W'(0));

        // More products
        run_mul("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0100);
        run_mul("mul_small", 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 4'b0000);
        tick();

        // Reset in the middle of a MUL
        issue(4'd3, 32'h0000_0002, 32'h0000_0003);
        for (int i = 0; i < 9; i++) tick();
        chk("abort_busy_res", result, 32'h0000_000F);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_outs", W'({out_valid, zero, cout, overflow, illegal}), W'(0));
        chk("abort_res", result, 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("abort_ready", W'(in_ready), W'(1));
        chk("abort_valid0", W'(out_valid), W'(0));
        for (int i = 0; i < 40; i++) begin
            tick();
            chk($sformatf("no_stale_%0d", i), W'(out_valid), W'(0));
        end
        run_op("add_after", 4'd2, 32'h0000_000A, 32'h0000_0014, 32'h0000_001E, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
